// File: rtl/q2_sequencer.sv
// Instruction-cycle controller for the 12-bit slice datapath: fetch/decode/deref/exec
// sequencing, memory request/ack handshake with timeout, and front-panel deposit/examine.
module q2_sequencer #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       run,
  input  logic       step,
  input  logic       dep,
  input  logic       exam,
  input  logic [3:0] ir,
  input  logic       flag,
  input  logic       mem_ack,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       wra,
  output logic       rda,
  output logic       wrx,
  output logic       rdx,
  output logic [3:0] xin_sel,
  output logic       incp_clk,
  output logic       nwrp,
  output logic       rdp,
  output logic       wrs,
  output logic       halted,
  output logic       bus_err
);

  // state  | meaning
  // HALT   | idle, front panel live (locked once bus_err is set)
  // FETCH  | P on abus, read instruction
  // DECODE | X <= operand, P+1, opcode latched
  // DEREF  | X <= mem[X] (wait phase, then wrx phase)
  // EXEC   | opcode action (wait phase for memory ops, then completion)
  // MEMW   | STA write of A to mem[X]
  // PANEL  | deposit/examine access at P, then P+1
  typedef enum logic [2:0] {
    S_HALT, S_FETCH, S_DECODE, S_DEREF, S_EXEC, S_MEMW, S_PANEL
  } state_t;

  localparam logic [3:0] CNT_LOAD  = 4'(WAIT_MAX - 1);
  localparam logic [3:0] XIN_DBUS  = 4'b1000;
  localparam logic [3:0] XIN_SHIFT = 4'b0010;
  localparam logic [2:0] OP_LDA = 3'd0, OP_STA = 3'd1, OP_ADD = 3'd2, OP_NAND = 3'd3,
                         OP_SHR = 3'd4, OP_JMP = 3'd5, OP_JZ = 3'd6, OP_HLT = 3'd7;

  state_t     r_state;
  logic [2:0] r_op;
  logic [3:0] r_cnt;
  logic       r_step;
  logic       r_wait;
  logic       r_pdep;

  logic [2:0] w_op;
  logic       w_enter_exec;
  logic       w_done;
  logic       w_timeout;

  always_comb begin
    w_op         = (r_state == S_DECODE) ? ir[3:1] : r_op;
    w_enter_exec = (r_state == S_DECODE && !ir[0]) || (r_state == S_DEREF && !r_wait);
    w_done       = (r_state == S_EXEC && !r_wait && r_op != OP_STA && r_op != OP_HLT) ||
                   (r_state == S_MEMW && mem_ack);
    w_timeout    = r_wait && !mem_ack && (r_cnt == 4'd0);
  end

  // Every strobe lands one cycle after the ack it answers, so a state that must
  // both strobe and then re-use the bus spends an extra cycle with r_wait low.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_HALT;
      r_op    <= OP_LDA;
      r_cnt   <= 4'd0;
      r_step  <= 1'b0;
      r_wait  <= 1'b0;
      r_pdep  <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      wra     <= 1'b0;
      rda     <= 1'b0;
      wrx     <= 1'b0;
      rdx     <= 1'b0;
      xin_sel <= 4'd0;
      incp_clk <= 1'b0;
      nwrp    <= 1'b1;
      rdp     <= 1'b0;
      wrs     <= 1'b0;
      halted  <= 1'b1;
      bus_err <= 1'b0;
    end else begin
      wra      <= 1'b0;
      wrx      <= 1'b0;
      xin_sel  <= 4'd0;
      incp_clk <= 1'b0;
      nwrp     <= 1'b1;
      wrs      <= 1'b0;
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;

      case (r_state)
        S_HALT: if (!bus_err) begin
          if (run || step) begin
            r_step <= !run;
            r_state <= S_FETCH;
            halted <= 1'b0;
            rdp    <= 1'b1;
            mem_rd <= 1'b1;
            r_wait <= 1'b1;
            r_cnt  <= CNT_LOAD;
          end else if (dep || exam) begin
            r_pdep  <= dep;
            r_state <= S_PANEL;
            halted  <= 1'b0;
            rdp     <= 1'b1;
            mem_wr  <= dep;
            mem_rd  <= !dep;
            r_wait  <= 1'b1;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_FETCH: if (mem_ack) begin
          rdp      <= 1'b0;
          mem_rd   <= 1'b0;
          r_wait   <= 1'b0;
          r_state  <= S_DECODE;
          wrx      <= 1'b1;
          xin_sel  <= XIN_DBUS;
          incp_clk <= 1'b1;
        end
        S_DECODE: begin
          r_op <= ir[3:1];
          if (ir[0]) begin
            r_state <= S_DEREF;
            rdx     <= 1'b1;
            mem_rd  <= 1'b1;
            r_wait  <= 1'b1;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_DEREF: if (r_wait && mem_ack) begin
          rdx     <= 1'b0;
          mem_rd  <= 1'b0;
          r_wait  <= 1'b0;
          wrx     <= 1'b1;
          xin_sel <= XIN_DBUS;
        end
        S_EXEC: begin
          if (r_wait) begin
            if (mem_ack) begin
              rdx    <= 1'b0;
              mem_rd <= 1'b0;
              r_wait <= 1'b0;
              wra    <= 1'b1;
              wrs    <= (r_op != OP_LDA);
            end
          end else if (r_op == OP_STA) begin
            r_state <= S_MEMW;
            mem_wr  <= 1'b1;
            r_wait  <= 1'b1;
            r_cnt   <= CNT_LOAD;
          end else if (r_op == OP_HLT) begin
            r_state <= S_HALT;
            halted  <= 1'b1;
            r_step  <= 1'b0;
          end
        end
        S_MEMW: ;
        S_PANEL: begin
          if (r_wait) begin
            if (mem_ack) begin
              mem_rd <= 1'b0;
              mem_wr <= 1'b0;
              r_wait <= 1'b0;
              wra    <= !r_pdep;
            end
          end else begin
            rdp      <= 1'b0;
            incp_clk <= 1'b1;
            r_state  <= S_HALT;
            halted   <= 1'b1;
          end
        end
        default: r_state <= S_HALT;
      endcase

      if (w_enter_exec) begin
        r_state <= S_EXEC;
        case (w_op)
          OP_LDA, OP_ADD, OP_NAND: begin
            rdx    <= 1'b1;
            mem_rd <= 1'b1;
            r_wait <= 1'b1;
            r_cnt  <= CNT_LOAD;
          end
          OP_STA: begin
            rdx <= 1'b1;
            rda <= 1'b1;
          end
          OP_SHR: begin
            wrx     <= 1'b1;
            xin_sel <= XIN_SHIFT;
            wrs     <= 1'b1;
          end
          OP_JMP: nwrp <= 1'b0;
          OP_JZ:  nwrp <= !flag;
          default: ;
        endcase
      end

      if (w_done) begin
        rdx    <= 1'b0;
        rda    <= 1'b0;
        mem_wr <= 1'b0;
        r_step <= 1'b0;
        r_wait <= 1'b0;
        if (run && !r_step) begin
          r_state <= S_FETCH;
          rdp     <= 1'b1;
          mem_rd  <= 1'b1;
          r_wait  <= 1'b1;
          r_cnt   <= CNT_LOAD;
        end else begin
          r_state <= S_HALT;
          halted  <= 1'b1;
        end
      end

      // A timed-out access leaves memory in an unknown state, so the sequencer
      // stays halted until reset rather than resuming on the next run.
      if (w_timeout) begin
        mem_rd  <= 1'b0;
        mem_wr  <= 1'b0;
        rdx     <= 1'b0;
        rda     <= 1'b0;
        rdp     <= 1'b0;
        r_wait  <= 1'b0;
        r_step  <= 1'b0;
        bus_err <= 1'b1;
        r_state <= S_HALT;
        halted  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_q2_sequencer.sv
// Directed bench for q2_sequencer: reset, step, run, indirect store, panel and timeout.
module tb_q2_sequencer;
  logic       clk = 1'b0;
  logic       nrst, run, step, dep, exam, flag, mem_ack;
  logic [3:0] ir;
  logic       mem_rd, mem_wr, wra, rda, wrx, rdx, incp_clk, nwrp, rdp, wrs, halted, bus_err;
  logic [3:0] xin_sel;

  int vectors = 0;
  int miscompares = 0;

  int n_wra = 0, n_incp = 0, n_nwrp = 0, n_wrs = 0, n_wrx_dbus = 0, n_rd_rise = 0, n_wr_rise = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;

  q2_sequencer #(.WAIT_MAX(15)) dut (
    .clk(clk), .nrst(nrst), .run(run), .step(step), .dep(dep), .exam(exam),
    .ir(ir), .flag(flag), .mem_ack(mem_ack), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .wra(wra), .rda(rda), .wrx(wrx), .rdx(rdx), .xin_sel(xin_sel),
    .incp_clk(incp_clk), .nwrp(nwrp), .rdp(rdp), .wrs(wrs),
    .halted(halted), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Event counters; each cycle's registered outputs are tallied at the next edge.
  always @(posedge clk) begin
    n_wra      <= n_wra + int'(wra);
    n_incp     <= n_incp + int'(incp_clk);
    n_nwrp     <= n_nwrp + int'(!nwrp);
    n_wrs      <= n_wrs + int'(wrs);
    n_wrx_dbus <= n_wrx_dbus + int'(wrx && xin_sel == 4'b1000);
    n_rd_rise  <= n_rd_rise + int'(mem_rd && !prev_rd);
    n_wr_rise  <= n_wr_rise + int'(mem_wr && !prev_wr);
    prev_rd    <= mem_rd;
    prev_wr    <= mem_wr;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_ack(input int late);
    int k;
    k = 0;
    while (!(mem_rd || mem_wr) && k < 40) begin
      tick();
      k++;
    end
    vectors++;
    if (k >= 40) begin
      miscompares++;
      $display("FAIL ack_wait: no request seen, mem_rd=%b mem_wr=%b, want a request", mem_rd, mem_wr);
    end else begin
      repeat (late) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; run = 1'b1;
    tick(); tick();
    vectors++;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL rst_halted: got %b want 1", halted); end
    vectors++;
    if (nwrp !== 1'b1) begin miscompares++; $display("FAIL rst_nwrp: got %b want 1", nwrp); end
    vectors++;
    if ({wra, rda, wrx, rdx, incp_clk, rdp, wrs, mem_rd, mem_wr, xin_sel, bus_err} !== 14'd0) begin
      miscompares++;
      $display("FAIL rst_strobes: got %b want 0", {wra, rda, wrx, rdx, incp_clk, rdp, wrs, mem_rd, mem_wr, xin_sel, bus_err});
    end
    nrst = 1'b1;
    tick();
    vectors++;
    if ({rdp, mem_rd, halted} !== 3'b110) begin
      miscompares++; $display("FAIL rst_release_fetch: {rdp,mem_rd,halted} got %b want 110", {rdp, mem_rd, halted});
    end
    nrst = 1'b0;
    tick();
    vectors++;
    if ({rdp, mem_rd, halted} !== 3'b001) begin
      miscompares++; $display("FAIL rst_mid_fetch: {rdp,mem_rd,halted} got %b want 001", {rdp, mem_rd, halted});
    end
    run = 1'b0; nrst = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    vectors++;
    if ({halted, mem_rd, wra, wrx} !== 4'b1000) begin
      miscompares++; $display("FAIL idle_ack: {halted,mem_rd,wra,wrx} got %b want 1000", {halted, mem_rd, wra, wrx});
    end
  endtask

  task automatic test_step_lda();
    int b_wra, b_incp, b_rd, b_wrs;
    b_wra = n_wra; b_incp = n_incp; b_rd = n_rd_rise; b_wrs = n_wrs;
    ir = 4'b0000;
    step = 1'b1;
    tick();
    step = 1'b0;
    do_ack(2);
    do_ack(2);
    repeat (8) tick();
    vectors++;
    if (n_wra - b_wra !== 1) begin miscompares++; $display("FAIL lda_wra: got %0d want 1", n_wra - b_wra); end
    vectors++;
    if (n_incp - b_incp !== 1) begin miscompares++; $display("FAIL lda_incp: got %0d want 1", n_incp - b_incp); end
    vectors++;
    if (n_wrs - b_wrs !== 0) begin miscompares++; $display("FAIL lda_wrs: got %0d want 0", n_wrs - b_wrs); end
    vectors++;
    if (n_rd_rise - b_rd !== 2) begin miscompares++; $display("FAIL lda_reads: got %0d want 2", n_rd_rise - b_rd); end
    vectors++;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL lda_halted: got %b want 1", halted); end
  endtask

  task automatic test_jz();
    int b_nwrp, b_rd;
    for (int f = 0; f < 2; f++) begin
      b_nwrp = n_nwrp; b_rd = n_rd_rise;
      ir = 4'b1100;
      flag = (f == 1);
      run = 1'b1;
      tick();
      run = 1'b0;
      do_ack(0);
      repeat (5) tick();
      vectors++;
      if (n_nwrp - b_nwrp !== f) begin
        miscompares++; $display("FAIL jz_flag%0d_nwrp: got %0d want %0d", f, n_nwrp - b_nwrp, f);
      end
      vectors++;
      if ({halted, n_rd_rise - b_rd} !== {1'b1, 32'd1}) begin
        miscompares++; $display("FAIL jz_flag%0d_end: halted=%b fetches=%0d want 1,1", f, halted, n_rd_rise - b_rd);
      end
    end
    flag = 1'b0;
  endtask

  task automatic test_back_to_back();
    int b_nwrp, b_rd, b_wr;
    b_nwrp = n_nwrp; b_rd = n_rd_rise; b_wr = n_wr_rise;
    ir = 4'b1010;
    run = 1'b1;
    tick();
    dep = 1'b1;
    tick();
    dep = 1'b0;
    do_ack(0);
    do_ack(1);
    run = 1'b0;
    repeat (5) tick();
    vectors++;
    if (n_rd_rise - b_rd !== 2) begin miscompares++; $display("FAIL b2b_fetches: got %0d want 2", n_rd_rise - b_rd); end
    vectors++;
    if (n_nwrp - b_nwrp !== 2) begin miscompares++; $display("FAIL b2b_jmp: got %0d want 2", n_nwrp - b_nwrp); end
    vectors++;
    if (n_wr_rise - b_wr !== 0) begin miscompares++; $display("FAIL b2b_dep_ignored: writes %0d want 0", n_wr_rise - b_wr); end
    vectors++;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL b2b_halted: got %b want 1", halted); end
  endtask

  task automatic test_sta_indirect();
    int b_x, b_rd, b_wr, k;
    b_x = n_wrx_dbus; b_rd = n_rd_rise; b_wr = n_wr_rise;
    ir = 4'b0011;
    step = 1'b1;
    tick();
    step = 1'b0;
    do_ack(0);
    do_ack(1);
    k = 0;
    while (!mem_wr && k < 20) begin tick(); k++; end
    vectors++;
    if (k >= 20) begin miscompares++; $display("FAIL sta_memw_start: mem_wr=%b want 1", mem_wr); end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({rdx, rda, mem_wr, mem_rd} !== 4'b1110) begin
        miscompares++; $display("FAIL sta_hold%0d: {rdx,rda,mem_wr,mem_rd} got %b want 1110", c, {rdx, rda, mem_wr, mem_rd});
      end
      tick();
    end
    do_ack(0);
    repeat (4) tick();
    vectors++;
    if (n_wrx_dbus - b_x !== 2) begin miscompares++; $display("FAIL sta_x_loads: got %0d want 2", n_wrx_dbus - b_x); end
    vectors++;
    if (n_rd_rise - b_rd !== 2) begin miscompares++; $display("FAIL sta_reads: got %0d want 2", n_rd_rise - b_rd); end
    vectors++;
    if ({n_wr_rise - b_wr} !== 32'd1) begin miscompares++; $display("FAIL sta_writes: got %0d want 1", n_wr_rise - b_wr); end
    vectors++;
    if ({halted, mem_wr, rdx, rda} !== 4'b1000) begin
      miscompares++; $display("FAIL sta_end: {halted,mem_wr,rdx,rda} got %b want 1000", {halted, mem_wr, rdx, rda});
    end
  endtask

  task automatic test_panel();
    int b_incp, b_wra, b_wr;
    b_incp = n_incp; b_wra = n_wra; b_wr = n_wr_rise;
    dep = 1'b1;
    tick();
    dep = 1'b0;
    vectors++;
    if ({rdp, mem_wr, mem_rd} !== 3'b110) begin
      miscompares++; $display("FAIL dep_req: {rdp,mem_wr,mem_rd} got %b want 110", {rdp, mem_wr, mem_rd});
    end
    do_ack(1);
    repeat (3) tick();
    vectors++;
    if (n_incp - b_incp !== 1) begin miscompares++; $display("FAIL dep_incp: got %0d want 1", n_incp - b_incp); end
    exam = 1'b1;
    tick();
    exam = 1'b0;
    vectors++;
    if ({rdp, mem_wr, mem_rd} !== 3'b101) begin
      miscompares++; $display("FAIL exam_req: {rdp,mem_wr,mem_rd} got %b want 101", {rdp, mem_wr, mem_rd});
    end
    do_ack(0);
    repeat (3) tick();
    vectors++;
    if (n_incp - b_incp !== 2) begin miscompares++; $display("FAIL panel_incp: got %0d want 2", n_incp - b_incp); end
    vectors++;
    if (n_wra - b_wra !== 1) begin miscompares++; $display("FAIL exam_wra: got %0d want 1", n_wra - b_wra); end
    vectors++;
    if (n_wr_rise - b_wr !== 1) begin miscompares++; $display("FAIL panel_writes: got %0d want 1", n_wr_rise - b_wr); end
    vectors++;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL panel_halted: got %b want 1", halted); end
  endtask

  task automatic test_timeout();
    int k;
    ir = 4'b0000;
    step = 1'b1;
    tick();
    step = 1'b0;
    k = 0;
    while (mem_rd && k < 30) begin tick(); k++; end
    vectors++;
    if (k !== 15) begin miscompares++; $display("FAIL timeout_len: mem_rd held %0d cycles want 15", k); end
    vectors++;
    if ({mem_rd, bus_err, halted} !== 3'b011) begin
      miscompares++; $display("FAIL timeout_state: {mem_rd,bus_err,halted} got %b want 011", {mem_rd, bus_err, halted});
    end
    run = 1'b1;
    tick(); tick();
    run = 1'b0;
    tick();
    vectors++;
    if ({mem_rd, bus_err, halted} !== 3'b011) begin
      miscompares++; $display("FAIL timeout_sticky: {mem_rd,bus_err,halted} got %b want 011", {mem_rd, bus_err, halted});
    end
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    vectors++;
    if ({bus_err, halted} !== 2'b01) begin
      miscompares++; $display("FAIL timeout_reset: {bus_err,halted} got %b want 01", {bus_err, halted});
    end
  endtask

  initial begin
    nrst = 1'b0; run = 1'b0; step = 1'b0; dep = 1'b0; exam = 1'b0;
    ir = 4'd0; flag = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_step_lda();
    test_jz();
    test_back_to_back();
    test_sta_indirect();
    test_panel();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
